// File: rtl/cla_pkg.sv
// Shared definitions for the sequential nibble-serial carry-lookahead adder.
package cla_pkg;

    // Width of one carry-lookahead slice; the datapath walks WIDTH in steps of this.
    localparam int SLICE_W = 4;

    // Controller states: waiting for operands, stepping nibbles, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count NIB slice passes; never less than one bit so a
    // single-nibble instance still has a legal counter.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: propagate/generate per bit,
// all internal carries expanded directly from c_in rather than rippled.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] s,
    output logic               c_out
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic               c1;
    logic               c2;
    logic               c3;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of products so no carry waits on the previous one.
    assign c1    = g[0] | (p[0] & c_in);
    assign c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s = p ^ {c3, c2, c1, c_in};

endmodule

// File: rtl/cla_seq_ctrl.sv
// Sequential add/subtract unit: operands are captured on accept, then one
// nibble per clock is pushed through a single 4-bit CLA slice, LSB first.
// A valid/ready handshake on both sides allows back-to-back operation.
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int               NIB   = WIDTH / SLICE_W;
    localparam int               CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NIB - 1);

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;       // already inverted for subtract
    logic [WIDTH-1:0]   sum_r;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               c_out_r;
    logic               ovf_r;

    logic               accept;
    logic               last_nib;
    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               c_nib;

    assign accept   = in_valid && in_ready;
    assign last_nib = (cnt == LAST);
    assign a_nib    = a_r[cnt*SLICE_W +: SLICE_W];
    assign b_nib    = b_r[cnt*SLICE_W +: SLICE_W];

    cla4_slice u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry),
        .s     (s_nib),
        .c_out (c_nib)
    );

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE can chain straight into RUN on a same-edge accept.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)   state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     in_ready = 1'b0;
            DONE:    begin
                         in_ready  = out_ready;
                         out_valid = 1'b1;
                     end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand capture on accept, then one slice pass per cycle while in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= op_sub ? ~b : b;
            sum_r <= '0;
            carry <= op_sub;          // +1 of the two's-complement negate
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_r[cnt*SLICE_W +: SLICE_W] <= s_nib;
            carry                         <= c_nib;
            cnt                           <= last_nib ? '0 : cnt + 1'b1;
            if (last_nib) begin
                c_out_r <= c_nib;
                ovf_r   <= (a_nib[SLICE_W-1] == b_nib[SLICE_W-1])
                        && (s_nib[SLICE_W-1] != a_nib[SLICE_W-1]);
            end
        end
    end

    assign sum   = sum_r;
    assign c_out = c_out_r;
    assign ovf   = ovf_r;

endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 The block SHALL have derived constant NIB = WIDTH/4, meaning the number of 4-bit slice passes per operation.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port op_sub, input, 1 bit: 0 selects A+B, 1 selects A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port c_out, output, 1 bit: carry out of the MSB; for subtract, 1 = no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 Accept SHALL occur when in_valid && in_ready is high at a rising edge; a, b and op_sub are registered at that edge, with b inverted when op_sub=1.
REQ-017 in_ready SHALL be 1 in IDLE, 0 in RUN, and equal out_ready in DONE.
REQ-018 Accept SHALL load the carry register with op_sub, clear the nibble counter to 0 and go to RUN.
REQ-019 In RUN, each cycle SHALL feed nibble[cnt] of A and B, plus the carry register, through one 4-bit carry-lookahead slice.
REQ-020 In RUN, each edge SHALL write the slice sum into sum nibble[cnt], load the slice carry-out into the carry register, and increment cnt.
REQ-021 Processing SHALL run LSB nibble first, one nibble per clock, with no skipping.
REQ-022 When cnt = NIB-1 at an edge in RUN, the FSM SHALL go to DONE.
REQ-023 On that same edge, c_out SHALL take the final carry and ovf SHALL take (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted B.
REQ-024 Latency SHALL be exact: accept at edge E, out_valid high from edge E+NIB.
REQ-025 In DONE, out_valid SHALL be 1; sum, c_out and ovf SHALL hold stable until the handshake.
REQ-026 DONE with out_ready=1 and in_valid=0 SHALL return the FSM to IDLE.
REQ-027 DONE with out_ready=1 and in_valid=1 SHALL accept the new request on the same edge and go directly to RUN, giving back-to-back operation with no bubble.
REQ-028 out_valid SHALL be 0 in IDLE and RUN.
REQ-029 The sum output SHALL be undefined-free: in RUN, partially written nibbles are visible on sum but out_valid=0.
REQ-030 in_valid in RUN SHALL be ignored; no queuing.
REQ-031 Input changes on a, b or op_sub after accept SHALL not affect the result.
REQ-032 A WIDTH=4 instance SHALL go from RUN to DONE after one cycle.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, cnt=0 and carry=0, regardless of clk.
REQ-034 Reset asserted during RUN or DONE SHALL discard the operation with no partial result delivered.
REQ-035 First accept after rst_n deasserts SHALL be at the first rising edge with rst_n high.

Structure
REQ-036 Shared package cla_pkg SHALL hold the FSM state enum, constant SLICE_W=4 and the nibble-count width function (clog2 of NIB).
REQ-037 Sub-module cla4_slice SHALL be the combinational 4-bit carry-lookahead slice: p/g per bit, internal carries c1..c3 in lookahead form, carry-out c4 and 4-bit sum.
REQ-038 cla_seq_ctrl SHALL instantiate exactly one cla4_slice; all sequencing, registers and handshake live in cla_seq_ctrl.

Verification (WIDTH=32)
REQ-039 Carry ripple: a=FFFFFFFF, b=00000001, add -> sum=00000000, c_out=1, ovf=0; out_valid rises exactly 8 edges after accept.
REQ-040 Subtract: a=00000005, b=00000007, sub -> sum=FFFFFFFE, c_out=0, ovf=0; and a=7, b=5, sub -> sum=00000002, c_out=1.
REQ-041 Overflow: a=7FFFFFFF, b=00000001, add -> sum=80000000, ovf=1, c_out=0; a=80000000, b=00000001, sub -> sum=7FFFFFFF, ovf=1.
REQ-042 Backpressure/back-to-back: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted on that edge, next out_valid 8 edges later.
REQ-043 Reset mid-op: rst_n low at RUN cnt=3 -> out_valid=0 and sum=0 immediately; after release, a fresh op 1+2 gives sum=00000003 with correct latency.
REQ-044 Randomised scoreboard: 1000 random add/sub ops with random in_valid/out_ready gaps -> every result matches the reference model, with no lost or duplicated results.
